logic_unit_arbiter: RTL and testbench

- Shares one 1-bit AND/OR logic cell (AND when select=1, OR when select=0) between two requesters.
- Each requester submits a WIDTH-bit operand pair and an op select through a valid/ready handshake.
- A round-robin arbiter grants one request at a time. A bit-serial sequencer then drives the cell one bit per cycle, LSB first, and returns the WIDTH-bit result tagged with the requester id.
- Sits between the exercise's test/driver modules and the shared logic cell.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_arbiter_logic_cell.sv | 13 +
 rtl/logic_unit_arbiter.sv | 156 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the logic-unit arbiter and its 1-bit logic cell.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_OR  = 1'b0;
    localparam logic OP_AND = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/logic_unit_arbiter_logic_cell.sv
// Shared 1-bit logic cell: AND when sel is OP_AND, OR otherwise.
module logic_cell
    import logic_unit_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic sel,
    output logic bit_out
);

    assign bit_out = (sel == OP_AND) ? (a_bit & b_bit) : (a_bit | b_bit);

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bit-serial logic cell between two requesters;
// each granted operation is evaluated LSB first, one bit per cycle.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sel,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sel,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             last_grant_q;

    logic             grant_id;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] bit_mask;
    logic             a_bit;
    logic             b_bit;
    logic             bit_out;
    logic [WIDTH-1:0] next_result;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end
    end

    // rst_n gates ready so nothing is reported as accepted while held in reset.
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && (grant_id == REQ0);
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && (grant_id == REQ1);
    assign accept     = req0_ready || req1_ready;

    assign bit_mask    = WIDTH'(1) << cnt_q;
    assign a_bit       = |(a_q & bit_mask);
    assign b_bit       = |(b_q & bit_mask);
    assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    assign next_result = result_q | ({WIDTH{bit_out}} & bit_mask);

    logic_cell u_logic_cell (
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .sel     (sel_q),
        .bit_out (bit_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_data = res_data_q;
    assign res_id   = res_id_q;

    // Operands are captured at the handshake so later input changes cannot
    // disturb the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 1'b0;
            id_q         <= 1'b0;
            result_q     <= '0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= REQ1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= (grant_id == REQ1) ? req1_a   : req0_a;
                        b_q          <= (grant_id == REQ1) ? req1_b   : req0_b;
                        sel_q        <= (grant_id == REQ1) ? req1_sel : req0_sel;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= '0;
                        result_q     <= '0;
                    end
                end
                RUN: begin
                    result_q <= next_result;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Published one cycle early so res_data is valid in DONE
                    // and holds until the next operation completes.
                    if (last_bit) begin
                        res_data_q <= next_result;
                        res_id_q   <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter (WIDTH=4): directed operations push
// expected results, a negedge monitor pops and compares each res_valid pulse.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 4;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sel;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sel;
    logic             req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [WIDTH-1:0] data, input int at);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got res_valid=1 id %0d data %0h, expected no result (cycle %0d)",
                         res_id, res_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id", 32'(res_id), 32'(mon_e.id));
                chk("res_data", 32'(res_data), 32'(mon_e.data));
                chk("res_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int c;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req0_sel   = 1'b0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_sel   = 1'b0;

        // Reset held: inputs toggle, outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = i[0];
            req1_valid = ~i[0];
            req0_a     = 4'($urandom);
            req1_b     = 4'($urandom);
            #1;
            chk("rst_req0_ready", 32'(req0_ready), 0);
            chk("rst_req1_ready", 32'(req1_ready), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_data", 32'(res_data), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_busy", 32'(busy), 0);
        end

        // AND on requester 0, released straight out of reset.
        tick();
        req0_valid = 1'b1;
        req0_a     = 4'b1100;
        req0_b     = 4'b1010;
        req0_sel   = 1'b1;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        c = cyc;
        chk("and_req0_ready", 32'(req0_ready), 1);
        chk("and_req1_ready", 32'(req1_ready), 0);
        push(1'b0, 4'b1000, c + 5);
        tick();
        req0_valid = 1'b0;
        req0_a     = 4'b0101;
        req0_b     = 4'b0101;
        req0_sel   = 1'b0;
        #1;
        chk("and_busy_run", 32'(busy), 1);
        tick(5);
        chk("and_after_valid", 32'(res_valid), 0);
        chk("and_after_busy", 32'(busy), 0);
        chk("and_hold_data", 32'(res_data), 32'(4'b1000));
        chk("and_hold_id", 32'(res_id), 0);

        // OR on requester 1 alone.
        req1_valid = 1'b1;
        req1_a     = 4'b1100;
        req1_b     = 4'b1010;
        req1_sel   = 1'b0;
        #1;
        c = cyc;
        chk("or_req1_ready", 32'(req1_ready), 1);
        chk("or_req0_ready", 32'(req0_ready), 0);
        push(1'b1, 4'b1110, c + 5);
        tick();
        req1_valid = 1'b0;
        req1_a     = 4'b0000;
        req1_b     = 4'b0000;
        tick(5);
        chk("or_hold_data", 32'(res_data), 32'(4'b1110));
        chk("or_hold_id", 32'(res_id), 1);

        // Simultaneous requests right after a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 4'b0011;
        req0_b     = 4'b0101;
        req0_sel   = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 4'b1111;
        req1_b     = 4'b0110;
        req1_sel   = 1'b1;
        #1;
        c = cyc;
        chk("tie_req0_ready", 32'(req0_ready), 1);
        chk("tie_req1_ready", 32'(req1_ready), 0);
        push(1'b0, 4'b0111, c + 5);
        push(1'b1, 4'b0110, c + 11);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("tie_req1_ready_busy", 32'(req1_ready), 0);
            chk("tie_req0_ready_busy", 32'(req0_ready), 0);
        end
        tick();
        chk("tie_second_req1_ready", 32'(req1_ready), 1);
        chk("tie_second_req0_ready", 32'(req0_ready), 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(5);
        chk("tie_idle_busy", 32'(busy), 0);

        // Fairness: both held valid for six operations.
        req0_valid = 1'b1;
        req0_a     = 4'b1001;
        req0_b     = 4'b0011;
        req0_sel   = 1'b1;
        req1_valid = 1'b1;
        req1_a     = 4'b1001;
        req1_b     = 4'b0011;
        req1_sel   = 1'b0;
        #1;
        c = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(1'b0, 4'b0001, c + 5 + 6 * k);
            else            push(1'b1, 4'b1011, c + 5 + 6 * k);
        end
        tick(31);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(6);
        chk("fair_idle_busy", 32'(busy), 0);

        // Reset in the middle of RUN discards the operation.
        req0_valid = 1'b1;
        req0_a     = 4'b1111;
        req0_b     = 4'b1111;
        req0_sel   = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_res_data", 32'(res_data), 0);
        chk("midrst_res_id", 32'(res_id), 0);
        tick(2);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 4'b0101;
        req0_b     = 4'b1010;
        req0_sel   = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 4'b0001;
        req1_b     = 4'b0001;
        req1_sel   = 1'b1;
        #1;
        c = cyc;
        chk("postrst_req0_ready", 32'(req0_ready), 1);
        chk("postrst_req1_ready", 32'(req1_ready), 0);
        push(1'b0, 4'b1111, c + 5);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
